// File: rtl/clock_pkg.sv
// Shared constants for the clock digit blocks: active-low 7-segment codes
// (bit order g,f,e,d,c,b,a), blink phase type and the blink divider default.
package clock_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned BLINK_DIV_DEFAULT = 25_000_000;

  typedef enum logic {
    BLINK_SHOWN  = 1'b0,
    BLINK_HIDDEN = 1'b1
  } blink_phase_t;

endpackage

// File: rtl/seg7_decode.sv
// Digit value to active-low 7-segment code; values above 9 are blanked.
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure lookup, shared by every clock digit
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hour_tens_digit.sv
// Tens-of-hours digit (0..2): counts carry toggles from the units digit,
// wraps at 24:00 and clears the units digit, supports manual set with a
// blinking display.
module hour_tens_digit
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_DIV   = BLINK_DIV_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       carry_tgl,
  input  logic [3:0] units_val,
  input  logic       set_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [6:0] Display,
  output logic [1:0] tens_val,
  output logic       units_clr
);

  localparam int unsigned MASK_CYC = SYNC_STAGES + 1;
  localparam int unsigned MW       = $clog2(MASK_CYC + 1);
  localparam int unsigned CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SYNC_STAGES-1:0] carry_sh, set_sh, inc_sh, dec_sh;
  logic [3:0]             units_sh [SYNC_STAGES];

  logic       carry_s, set_s, inc_s, dec_s;
  logic [3:0] units_s;

  logic          carry_prev, inc_prev, dec_prev;
  logic [MW-1:0] mask_cnt;
  logic          events_ok;
  logic          carry_ev, inc_ev, dec_ev, rollover;

  logic [1:0]   tens_nxt;
  logic [3:0]   seg_in;
  logic [6:0]   seg_code;
  logic [CW-1:0] blink_cnt;
  blink_phase_t  phase;

  // Synchronizer chains for every asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_sh <= '0;
      set_sh   <= '0;
      inc_sh   <= '0;
      dec_sh   <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) units_sh[i] <= '0;
    end else begin
      carry_sh[0] <= carry_tgl;
      set_sh[0]   <= set_mode;
      inc_sh[0]   <= btn_inc;
      dec_sh[0]   <= btn_dec;
      units_sh[0] <= units_val;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        carry_sh[i] <= carry_sh[i-1];
        set_sh[i]   <= set_sh[i-1];
        inc_sh[i]   <= inc_sh[i-1];
        dec_sh[i]   <= dec_sh[i-1];
        units_sh[i] <= units_sh[i-1];
      end
    end
  end

  assign carry_s = carry_sh[SYNC_STAGES-1];
  assign set_s   = set_sh[SYNC_STAGES-1];
  assign inc_s   = inc_sh[SYNC_STAGES-1];
  assign dec_s   = dec_sh[SYNC_STAGES-1];
  assign units_s = units_sh[SYNC_STAGES-1];

  // Edge trackers always follow the synchronized inputs; only the event
  // outputs are masked, so neither reset release nor a mode change can
  // leave a stale edge behind.
  assign events_ok = (mask_cnt == MW'(MASK_CYC));
  assign carry_ev  = events_ok & (carry_s ^ carry_prev);
  assign inc_ev    = events_ok & inc_s & ~inc_prev;
  assign dec_ev    = events_ok & dec_s & ~dec_prev;

  // 24:00 can only fire while tens_val = 2 and it forces tens_val to 0,
  // so a re-fire needs the digit to climb back to 2 first.
  assign rollover  = !set_s && (tens_val == 2'd2) && (units_s == 4'd4);

  // Next digit value: illegal recovery, then set-mode buttons, then run-mode
  // rollover (which also covers a coincident carry), then carry
  always_comb begin
    tens_nxt = tens_val;
    if (tens_val == 2'd3) begin
      tens_nxt = 2'd0;
    end else if (set_s) begin
      if (inc_ev && !dec_ev)
        tens_nxt = (tens_val == 2'd2) ? 2'd0 : tens_val + 2'd1;
      else if (dec_ev && !inc_ev)
        tens_nxt = (tens_val == 2'd0) ? 2'd2 : tens_val - 2'd1;
    end else if (rollover) begin
      tens_nxt = 2'd0;
    end else if (carry_ev) begin
      tens_nxt = (tens_val == 2'd2) ? 2'd0 : tens_val + 2'd1;
    end
  end

  // Illegal digit is displayed as 0
  assign seg_in = (tens_val == 2'd3) ? 4'd0 : {2'b00, tens_val};

  seg7_decode u_seg (
    .value (seg_in),
    .seg   (seg_code)
  );

  // Digit state, edge tracking, post-reset mask, blink timer and display
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_val   <= '0;
      units_clr  <= 1'b0;
      carry_prev <= 1'b0;
      inc_prev   <= 1'b0;
      dec_prev   <= 1'b0;
      mask_cnt   <= '0;
      blink_cnt  <= '0;
      phase      <= BLINK_SHOWN;
      Display    <= SEG_0;
    end else begin
      carry_prev <= carry_s;
      inc_prev   <= inc_s;
      dec_prev   <= dec_s;
      if (!events_ok) mask_cnt <= mask_cnt + 1'b1;

      tens_val  <= tens_nxt;
      units_clr <= (tens_val != 2'd3) && rollover;

      if (!set_s) begin
        blink_cnt <= '0;
        phase     <= BLINK_SHOWN;
      end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= (phase == BLINK_SHOWN) ? BLINK_HIDDEN : BLINK_SHOWN;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      Display <= (set_s && phase == BLINK_HIDDEN) ? SEG_BLANK : seg_code;
    end
  end

endmodule

// File: tb/tb_hour_tens_digit.sv
// Directed bench for hour_tens_digit (BLINK_DIV = 4, SYNC_STAGES = 2).
module tb_hour_tens_digit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       carry_tgl;
  logic [3:0] units_val;
  logic       set_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [6:0] Display;
  logic [1:0] tens_val;
  logic       units_clr;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] DB = 7'b1111111;

  hour_tens_digit #(.BLINK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .carry_tgl (carry_tgl),
    .units_val (units_val),
    .set_mode  (set_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .Display   (Display),
    .tens_val  (tens_val),
    .units_clr (units_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with carry held high
    rst_n = 1'b0; carry_tgl = 1'b1; units_val = 4'd0;
    set_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick(3);
    chk("rst_tens", {5'b0, tens_val}, 7'd0);
    chk("rst_disp", Display, D0);
    chk("rst_clr", {6'b0, units_clr}, 7'd0);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_tens", {5'b0, tens_val}, 7'd0);
    chk("post_rst_disp", Display, D0);

    // Run mode carry sequence 1, 2, 0
    carry_tgl = 1'b0; tick(3);
    chk("carry1_tens", {5'b0, tens_val}, 7'd1);
    chk("carry1_disp_lag", Display, D0);
    tick(1);
    chk("carry1_disp", Display, D1);
    tick(6);
    carry_tgl = 1'b1; tick(3);
    chk("carry2_tens", {5'b0, tens_val}, 7'd2);
    tick(1);
    chk("carry2_disp", Display, D2);
    tick(6);
    carry_tgl = 1'b0; tick(3);
    chk("carry3_tens", {5'b0, tens_val}, 7'd0);
    tick(1);
    chk("carry3_disp", Display, D0);
    tick(6);

    // 24:00 rollover
    units_val = 4'd3; tick(4);
    carry_tgl = 1'b1; tick(10);
    carry_tgl = 1'b0; tick(10);
    chk("pre24_tens", {5'b0, tens_val}, 7'd2);
    chk("pre24_clr", {6'b0, units_clr}, 7'd0);
    units_val = 4'd4; tick(2);
    chk("r24_early_clr", {6'b0, units_clr}, 7'd0);
    chk("r24_early_tens", {5'b0, tens_val}, 7'd2);
    tick(1);
    chk("r24_clr", {6'b0, units_clr}, 7'd1);
    chk("r24_tens", {5'b0, tens_val}, 7'd0);
    tick(1);
    chk("r24_clr_width", {6'b0, units_clr}, 7'd0);
    tick(10);
    chk("r24_hold_clr", {6'b0, units_clr}, 7'd0);
    chk("r24_hold_tens", {5'b0, tens_val}, 7'd0);

    // Re-arm: climb back to 2 with units at 4 fires again
    carry_tgl = 1'b1; tick(10);
    chk("rearm_tens1", {5'b0, tens_val}, 7'd1);
    carry_tgl = 1'b0; tick(4);
    chk("rearm_clr", {6'b0, units_clr}, 7'd1);
    chk("rearm_tens", {5'b0, tens_val}, 7'd0);
    tick(1);

    // Reset on the edge that would raise units_clr
    carry_tgl = 1'b1; tick(10);
    carry_tgl = 1'b0; tick(3);
    chk("prerst_tens", {5'b0, tens_val}, 7'd2);
    rst_n = 1'b0; tick(1);
    chk("midrst_clr", {6'b0, units_clr}, 7'd0);
    chk("midrst_tens", {5'b0, tens_val}, 7'd0);
    tick(2);
    rst_n = 1'b1; units_val = 4'd0; tick(8);
    chk("rerst_tens", {5'b0, tens_val}, 7'd0);
    chk("rerst_disp", Display, D0);
    chk("rerst_clr", {6'b0, units_clr}, 7'd0);

    // Set mode: dec 0->2, blink every 4 cycles, carry ignored
    set_mode = 1'b1; tick(1);
    btn_dec = 1'b1; tick(1);
    btn_dec = 1'b0; tick(2);
    chk("set_dec_tens", {5'b0, tens_val}, 7'd2);
    chk("blink_e4", Display, D0);
    tick(1); chk("blink_e5", Display, D2);
    tick(1); chk("blink_e6", Display, D2);
    tick(1); chk("blink_e7", Display, DB);
    tick(3); chk("blink_e10", Display, DB);
    tick(1); chk("blink_e11", Display, D2);
    tick(3); chk("blink_e14", Display, D2);
    tick(1); chk("blink_e15", Display, DB);
    carry_tgl = 1'b1; tick(5);
    chk("set_carry_ign", {5'b0, tens_val}, 7'd2);
    set_mode = 1'b0; tick(8);
    chk("leave_set_tens", {5'b0, tens_val}, 7'd2);
    chk("leave_set_disp", Display, D2);
    btn_inc = 1'b1; tick(2);
    btn_inc = 1'b0; tick(5);
    chk("run_btn_ign", {5'b0, tens_val}, 7'd2);

    // Set mode: inc wrap, simultaneous inc+dec, inc sequence, dec
    set_mode = 1'b1; tick(4);
    btn_inc = 1'b1; tick(2);
    btn_inc = 1'b0; tick(3);
    chk("inc_wrap", {5'b0, tens_val}, 7'd0);
    btn_inc = 1'b1; btn_dec = 1'b1; tick(2);
    btn_inc = 1'b0; btn_dec = 1'b0; tick(3);
    chk("inc_dec_same", {5'b0, tens_val}, 7'd0);
    btn_inc = 1'b1; tick(2); btn_inc = 1'b0; tick(3);
    chk("inc_1", {5'b0, tens_val}, 7'd1);
    btn_inc = 1'b1; tick(2); btn_inc = 1'b0; tick(3);
    chk("inc_2", {5'b0, tens_val}, 7'd2);
    btn_inc = 1'b1; tick(2); btn_inc = 1'b0; tick(3);
    chk("inc_0", {5'b0, tens_val}, 7'd0);
    btn_dec = 1'b1; tick(2); btn_dec = 1'b0; tick(3);
    chk("dec_2", {5'b0, tens_val}, 7'd2);
    btn_dec = 1'b1; tick(2); btn_dec = 1'b0; tick(3);
    chk("dec_1", {5'b0, tens_val}, 7'd1);
    set_mode = 1'b0; tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hour_tens_digit.md
HOUR_TENS_DIGIT -- requirements
Module: hour_tens_digit

Interface
REQ-001 Parameter: BLINK_DIV, default 25_000_000, clk cycles per blink half-period in set mode.
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth for every asynchronous input.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 carry_tgl  input  1  asynchronous toggle-carry from the hour-units counter; each level change is one carry event.
REQ-006 units_val  input  4  hour-units digit value, 0..9, asynchronous to clk.
REQ-007 set_mode  input  1  asynchronous level; 1 = manual set, 0 = run.
REQ-008 btn_inc  input  1  asynchronous push-button; rising edge = increment.
REQ-009 btn_dec  input  1  asynchronous push-button; rising edge = decrement.
REQ-010 Display  output  7  active-low 7-segment code for the tens-of-hours digit.
REQ-011 tens_val  output  2  current tens digit, 0..2.
REQ-012 units_clr  output  1  one-cycle pulse ordering the units counter to clear at 24:00.

Function
REQ-013 carry_tgl, units_val, set_mode, btn_inc and btn_dec shall each pass through SYNC_STAGES flops before use.
REQ-014 A carry event shall be any change of the synchronized carry_tgl between consecutive cycles.
REQ-015 A button event shall be a 0->1 transition of the synchronized button.
REQ-016 In run mode, a carry event shall set tens_val to 0 if tens_val = 2, otherwise to tens_val + 1, one cycle after detection.
REQ-017 In run mode, when tens_val = 2 and synchronized units_val = 4, the block shall set tens_val to 0 and assert units_clr for exactly one cycle.
REQ-018 units_clr shall not reassert until tens_val has left 0 and returned to 2.
REQ-019 A carry event and the 24:00 condition in the same cycle shall give tens_val = 0 with a single units_clr pulse.
REQ-020 In set mode, carry events shall be ignored, but the edge-tracking register shall keep updating so that leaving set mode produces no spurious event.
REQ-021 In set mode, inc shall step 0->1->2->0 and dec shall step 0->2->1->0; inc and dec events in the same cycle shall leave tens_val unchanged.
REQ-022 Button events in run mode shall be ignored.
REQ-023 Display shall be registered with one cycle of latency from tens_val: 0=1000000, 1=1111001, 2=0100100.
REQ-024 In set mode, a counter shall toggle a blink phase every BLINK_DIV cycles; while the phase is hidden, Display = 1111111.
REQ-025 On entering set mode, the blink counter shall restart with the phase visible.
REQ-026 An illegal tens_val (3) shall never occur; if it does, it shall load 0 on the next cycle and Display shall show the 0 code.

Reset
REQ-027 While rst_n = 0: tens_val = 0, Display = 1000000, units_clr = 0, blink counter = 0, blink phase visible, and all synchronizer and edge registers = 0.
REQ-028 Carry and button event detection shall be masked for SYNC_STAGES+1 cycles after reset release, with edge registers tracking the synchronized inputs throughout.
REQ-029 Reset asserted mid-operation, including mid-blink or during a units_clr pulse, shall take priority in that cycle.

Structure
REQ-030 Shared package clock_pkg shall hold the segment constants SEG_0..SEG_9 and SEG_BLANK, plus the BLINK_DIV default.
REQ-031 The segment lookup shall be a sub-module seg7_decode (4-bit value in, 7-bit active-low code out, SEG_BLANK for values above 9), reused by the other clock digits.

Verification
REQ-032 Reset with carry_tgl held at 1 -> tens_val = 0, Display = 1000000, and no increment after release.
REQ-033 Run mode, toggle carry_tgl three times spaced 10 cycles apart -> tens_val sequence 1, 2, 0; Display matches one cycle after each change.
REQ-034 Run mode, tens_val = 2, drive units_val 3 then 4 -> one units_clr pulse exactly one cycle wide, tens_val = 0; holding units_val at 4 produces no second pulse.
REQ-035 Set mode, BLINK_DIV = 4, pulse btn_dec once -> tens_val 0->2; Display alternates 0100100 and 1111111 every 4 cycles; a carry toggle has no effect; leaving set mode produces no event.
REQ-036 Set mode, btn_inc and btn_dec rise in the same cycle -> tens_val unchanged; then btn_inc alone three times -> 1, 2, 0.
REQ-037 Run mode, assert rst_n = 0 during a units_clr cycle -> units_clr = 0 and tens_val = 0 in that cycle.
